// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the round-robin bus arbiter
// Purpose: arbiter state encoding, master count, index width and the reset
//          value of the last-granted index.
// Ports:   none (package).
package bus_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int IDX_W       = 2;

  // Starting from 3 makes master 0 the first candidate after reset.
  localparam logic [IDX_W-1:0] LAST_IDX_RST = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational four-way round-robin winner selection
// Purpose: searches req upward from (last_idx+1) mod 4 with wrap-around and
//          reports the first requesting index.
// Ports:   req      in  [3:0] per-master requests
//          last_idx in  [1:0] most recently released master
//          winner   out [1:0] selected master (0 when nobody requests)
//          any_req  out       at least one request is set
module rr_pick4
  import bus_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_idx,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    cand    = '0;
    any_req = |req;
    // Offsets 1..4; offset 4 wraps back to last_idx itself, so a lone
    // requester that was just released can still win.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// rtl/bus_arbiter_rr4.sv - four-master round-robin bus arbiter with tenure limit
// Purpose: grants a shared bus to one master at a time, revokes a grant after
//          MAX_HOLD cycles when others wait, and inserts TURNAROUND idle
//          cycles between owners so the downstream select decoder tri-states.
// Ports:   clk       in        system clock, rising edge
//          rst       in        asynchronous active-high reset
//          req       in  [3:0] per-master bus requests
//          grant_idx out [1:0] granted master index (decoder select)
//          grant_en  out       grant valid (decoder enable)
//          grant_oh  out [3:0] one-hot grant, zero while grant_en=0
//          preempt   out       one-cycle pulse when MAX_HOLD revokes a grant
module bus_arbiter_rr4
  import bus_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_en,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic                   preempt
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TURN_W = $clog2(TURNAROUND + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

  state_t                   state;
  logic [HOLD_W-1:0]        hold_cnt;
  logic [TURN_W-1:0]        turn_cnt;
  logic [IDX_W-1:0]         last_idx;

  logic [IDX_W-1:0]         winner;
  logic                     any_req;
  logic [NUM_MASTERS-1:0]   win_oh;
  logic                     others_req;
  logic                     owner_req;

  // One picker serves both the IDLE pick and the TURN-exit pick; last_idx
  // is already updated at release, so both use the same register.
  rr_pick4 u_pick (
    .req      (req),
    .last_idx (last_idx),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign win_oh     = NUM_MASTERS'(1) << winner;
  assign owner_req  = req[grant_idx];
  // grant_oh marks the current owner while in GRANT, so masking it leaves
  // only the competing masters.
  assign others_req = |(req & ~grant_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_en  <= 1'b0;
      grant_oh  <= '0;
      grant_idx <= '0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
      last_idx  <= LAST_IDX_RST;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= winner;
            grant_oh  <= win_oh;
            grant_en  <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end

        GRANT: begin
          if (!owner_req || (hold_cnt == HOLD_LAST && others_req)) begin
            // grant_idx is left untouched so the decoder select stays
            // stable while the bus is released.
            grant_en <= 1'b0;
            grant_oh <= '0;
            last_idx <= grant_idx;
            turn_cnt <= '0;
            preempt  <= owner_req;
            state    <= TURN;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            if (any_req) begin
              grant_idx <= winner;
              grant_oh  <= win_oh;
              grant_en  <= 1'b1;
              hold_cnt  <= '0;
              state     <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          grant_en <= 1'b0;
          grant_oh <= '0;
        end
      endcase
    end
  end

endmodule
